bitfusion_seq_ctrl: RTL and testbench
=====================================

# bitfusion_seq_ctrl

Parametrised sequencer for the BitFusion systolic array. It accepts a start command with precision and reduction-length configuration, then generates the diagonally skewed `input_rd_en`/`weight_rd_en` wavefronts, the accumulator clear, and a completion/valid indication for `OBUF`. The sequencer sits between the layer-level controller and the `bitfusion` array. It replaces hand-driven enable sequencing, and it generalises that sequencing to any ARRAY_SIZE, any reduction length, and a configurable drain latency.

## Interface
- `ARRAY_SIZE`, default 2: rows and columns of the square PE array (N). Must be ≥ 1.
- `K_W`, default 8: width of the reduction-length field.
- `DRAIN_CYC`, default 2: cycles from the last weight read until `OBUF` is stable. Must be ≥ 0.

- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `nRST`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Job request, sampled on the rising edge.
- `abort`: input, 1 bit. Synchronous job cancel.
- `input_bitwidth`: input, 3 bits. Input precision code: 000 = 1b, 001 = 2b, 010 = 4b, 011 = 8b.
- `weight_bitwidth`: input, 3 bits. Weight precision code, same encoding as `input_bitwidth`.
- `k_len`: input, K_W bits. Number of DATA_W words streamed per row.
- `cfg_input_bitwidth`: output, 3 bits. Input precision latched for the current job.
- `cfg_weight_bitwidth`: output, 3 bits. Weight precision latched for the current job.
- `input_rd_en`: output, N bits. Per-row IBUF read enable.
- `weight_rd_en`: output, N·N bits. Per-PE WBUF read enable; bit index is r·N + c.
- `acc_clear`: output, N bits. Accumulator clear, one bit per row.
- `busy`: output, 1 bit. A job is active.
- `done`: output, 1 bit. One-cycle completion pulse.
- `obuf_valid`: output, 1 bit. `OBUF` holds the final result; high in the same cycle as `done`.
- `cfg_error`: output, 1 bit. One-cycle pulse when a start is rejected.

## Operation
- **States:** IDLE, CLEAR, STREAM, DRAIN, DONE. All outputs are registered and decoded from state and counters (Moore).
- **Accepting a start:**
  - `start` is accepted only in IDLE or DONE, and only when `abort` = 0.
  - A start is legal when both bitwidth codes are ≤ 011 and `k_len` ≠ 0.
  - On a legal start: latch both bitwidth codes into the `cfg_*` outputs, latch `k_len`, and move to CLEAR.
  - On an illegal start: pulse `cfg_error` for 1 cycle, latch nothing, and move to (or stay in) IDLE.
- **CLEAR** lasts 1 cycle. `acc_clear` = all ones. Then move to STREAM with the stream counter t = 0.
- **STREAM** lasts T = k_len + 2(N−1) cycles, with t running from 0 to T−1.
  - `input_rd_en[r]` = 1 iff r ≤ t ≤ r + k_len − 1.
  - `weight_rd_en[r·N+c]` = 1 iff r+c ≤ t ≤ r+c+k_len−1.
  - When t = T−1, move to DRAIN, or directly to DONE if DRAIN_CYC = 0.
- **DRAIN** lasts DRAIN_CYC cycles with all read enables at 0. Then move to DONE.
- **DONE** lasts 1 cycle: `done` = 1, `obuf_valid` = 1, `busy` = 0. Then move to IDLE, unless a new legal start is accepted in that cycle (back-to-back jobs).
- **busy** = 1 in CLEAR, STREAM and DRAIN; 0 otherwise.
- **start during busy:** ignored. No `cfg_error`, no state change.
- **abort:**
  - In CLEAR, STREAM or DRAIN: on the next edge, go to IDLE with all enables 0. No `done`, no `obuf_valid`.
  - In IDLE or DONE: no effect, except that it blocks a simultaneous start.
- **Counters:** t is sized to hold K_W + clog2(2N) bits, so no overflow occurs at `k_len` = 2^K_W − 1. The drain counter is clog2(DRAIN_CYC+1) bits.
- **cfg_* outputs:** hold their value until the next accepted start. Reset value is 000.

## Timing
- **Reset:** `nRST` low forces IDLE immediately (asynchronously), whether idle or mid-job. All outputs go to 0, including `cfg_*`. The first start is sampled on the first rising edge after `nRST` rises.
- **Cycle numbering:** edge 0 is the edge at which `start` is accepted.
  - Cycle 1: CLEAR.
  - Cycles 2 to T+1: STREAM.
  - Cycles T+2 to T+1+DRAIN_CYC: DRAIN.
  - Cycle T+2+DRAIN_CYC: DONE.
- **Latency** from start to `done` = T + DRAIN_CYC + 2 cycles.
- **Wavefront:** PE (r,c) first reads at stream cycle r+c. Row r input first reads at stream cycle r. Each PE and each row reads exactly `k_len` consecutive cycles.
- **Back-to-back:** a start accepted in DONE puts CLEAR in the very next cycle, giving one idle-free cycle between jobs.
- **Simultaneous start and abort:** abort wins and the start is dropped.
- The external controller drives `start`/`abort` away from the rising edge; the block has no combinational input-to-output paths.

## Test plan
- **Reset mid-job:** N=2, `k_len`=4, pull `nRST` low during STREAM t=2 → all enables, `busy` and `cfg_*` go to 0 immediately. After release, IDLE; the next start behaves normally.
- **Basic wavefront:** N=2, `k_len`=1, DRAIN_CYC=2, codes 001/001 → T=3 and `done` at cycle 7.
  - `acc_clear`=11 in cycle 1.
  - Cycle 2: `input_rd_en[0]` and `weight_rd_en[0]` high.
  - Cycle 3: `input_rd_en[1]`, `weight_rd_en[1]` and `weight_rd_en[2]` high.
  - Cycle 4: `weight_rd_en[3]` high.
  - `cfg_*` = 001 throughout.
- **Longer job, wider array:** N=4, `k_len`=3 → each `weight_rd_en` bit is high for exactly 3 cycles starting at stream cycle r+c. T=9, so `done` falls at cycle 13 with DRAIN_CYC=2.
- **Illegal configuration:**
  - `input_bitwidth`=101 → `cfg_error` pulses 1 cycle, `busy` stays 0, `cfg_*` are unchanged.
  - `k_len`=0 → same response.
- **Abort:** abort in DRAIN → IDLE the next cycle with no `done`. Start and abort asserted together in IDLE → start ignored.
- **Back-to-back and busy start:** start during STREAM → ignored. A new start in the DONE cycle → CLEAR the next cycle, with the new bitwidths latched.

Source files
------------

// File: rtl/bitfusion_seq_ctrl.sv
// Sequencer for the BitFusion systolic array: it latches a job's configuration and
// generates the diagonally skewed read-enable wavefronts, the accumulator clear and
// the completion pulse.
module bitfusion_seq_ctrl #(
    parameter int ARRAY_SIZE = 2,
    parameter int K_W        = 8,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                             clk,
    input  logic                             nRST,
    input  logic                             start,
    input  logic                             abort,
    input  logic [2:0]                       input_bitwidth,
    input  logic [2:0]                       weight_bitwidth,
    input  logic [K_W-1:0]                   k_len,
    output logic [2:0]                       cfg_input_bitwidth,
    output logic [2:0]                       cfg_weight_bitwidth,
    output logic [ARRAY_SIZE-1:0]            input_rd_en,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] weight_rd_en,
    output logic [ARRAY_SIZE-1:0]            acc_clear,
    output logic                             busy,
    output logic                             done,
    output logic                             obuf_valid,
    output logic                             cfg_error
);
    localparam int N  = ARRAY_SIZE;
    localparam int TW = K_W + $clog2(2 * N);
    localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [TW-1:0] SKEW   = TW'(2 * (N - 1));

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   t_reg, t_next;
    logic [DW-1:0]   d_reg, d_next;
    logic [K_W-1:0]  k_reg, k_next;
    logic [2:0]      cfg_ib_next, cfg_wb_next;
    logic            err_next;
    logic            accept_window, start_legal, stream_next, busy_next;
    logic [N-1:0]    in_en_next;
    logic [N*N-1:0]  w_en_next;

    assign accept_window = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start && !abort;
    assign start_legal   = (input_bitwidth <= 3'd3) && (weight_bitwidth <= 3'd3) && (k_len != '0);

    always_comb begin
        state_next  = state_reg;
        t_next      = t_reg;
        d_next      = d_reg;
        k_next      = k_reg;
        cfg_ib_next = cfg_input_bitwidth;
        cfg_wb_next = cfg_weight_bitwidth;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (accept_window) begin
                    if (start_legal) begin
                        state_next  = ST_CLEAR;
                        k_next      = k_len;
                        cfg_ib_next = input_bitwidth;
                        cfg_wb_next = weight_bitwidth;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                t_next     = '0;
                state_next = abort ? ST_IDLE : ST_STREAM;
            end
            ST_STREAM: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (t_reg == TW'(k_reg) + SKEW - TW'(1)) begin
                    d_next     = '0;
                    state_next = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    t_next = t_reg + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (d_reg == D_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    d_next = d_reg + DW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign stream_next = (state_next == ST_STREAM);
    assign busy_next   = (state_next == ST_CLEAR) || stream_next || (state_next == ST_DRAIN);

    // Enables are decoded from the upcoming state/counter so the registered outputs line up with it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            assign in_en_next[gi] = stream_next && (t_next >= TW'(gi))
                                    && (t_next < TW'(gi) + TW'(k_next));
        end
        for (genvar gi = 0; gi < N * N; gi++) begin : g_pe
            localparam int DIAG = (gi / N) + (gi % N);
            assign w_en_next[gi] = stream_next && (t_next >= TW'(DIAG))
                                   && (t_next < TW'(DIAG) + TW'(k_next));
        end
    endgenerate

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_reg           <= ST_IDLE;
            t_reg               <= '0;
            d_reg               <= '0;
            k_reg               <= '0;
            cfg_input_bitwidth  <= '0;
            cfg_weight_bitwidth <= '0;
            input_rd_en         <= '0;
            weight_rd_en        <= '0;
            acc_clear           <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            obuf_valid          <= 1'b0;
            cfg_error           <= 1'b0;
        end else begin
            state_reg           <= state_next;
            t_reg               <= t_next;
            d_reg               <= d_next;
            k_reg               <= k_next;
            cfg_input_bitwidth  <= cfg_ib_next;
            cfg_weight_bitwidth <= cfg_wb_next;
            input_rd_en         <= in_en_next;
            weight_rd_en        <= w_en_next;
            acc_clear           <= (state_next == ST_CLEAR) ? '1 : '0;
            busy                <= busy_next;
            done                <= (state_next == ST_DONE);
            obuf_valid          <= (state_next == ST_DONE);
            cfg_error           <= err_next;
        end
    end
endmodule

// File: tb/tb_bitfusion_seq_ctrl.sv
// Self-checking bench: directed scenarios plus random start/abort traffic, compared
// each cycle against a job-timeline model keyed on the cycle number since acceptance.
module tb_bitfusion_seq_ctrl;
    localparam int N  = 2;
    localparam int KW = 4;
    localparam int DC = 2;

    logic            clk = 1'b0;
    logic            nRST = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [2:0]      input_bitwidth = '0;
    logic [2:0]      weight_bitwidth = '0;
    logic [KW-1:0]   k_len = '0;
    logic [2:0]      cfg_input_bitwidth, cfg_weight_bitwidth;
    logic [N-1:0]    input_rd_en, acc_clear;
    logic [N*N-1:0]  weight_rd_en;
    logic            busy, done, obuf_valid, cfg_error;

    bitfusion_seq_ctrl #(.ARRAY_SIZE(N), .K_W(KW), .DRAIN_CYC(DC)) dut (
        .clk(clk), .nRST(nRST), .start(start), .abort(abort),
        .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth), .k_len(k_len),
        .cfg_input_bitwidth(cfg_input_bitwidth), .cfg_weight_bitwidth(cfg_weight_bitwidth),
        .input_rd_en(input_rd_en), .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
        .busy(busy), .done(done), .obuf_valid(obuf_valid), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_act says a job (including its DONE cycle) is in flight; m_cyc is the cycle number since acceptance.
    bit         m_act = 1'b0;
    int         m_cyc = 0;
    int         m_k   = 0;
    int         m_len = 0;
    logic [2:0] m_ib  = '0;
    logic [2:0] m_wb  = '0;
    bit         m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit a, input logic [2:0] i, input logic [2:0] w,
                              input logic [KW-1:0] k);
        bit idle_like;
        idle_like = !m_act || (m_cyc == m_len);
        m_err = 1'b0;
        if (idle_like) begin
            m_act = 1'b0;
            if (s && !a) begin
                if (i <= 3 && w <= 3 && k != 0) begin
                    m_act = 1'b1;
                    m_cyc = 1;
                    m_k   = int'(k);
                    m_len = m_k + 2 * (N - 1) + 2 + DC;
                    m_ib  = i;
                    m_wb  = w;
                    $display("job accepted: k_len=%0d ib=%0d wb=%0d done expected at cycle %0d",
                             m_k, i, w, m_len);
                end else begin
                    m_err = 1'b1;
                    $display("start rejected: k_len=%0d ib=%0d wb=%0d", k, i, w);
                end
            end
        end else if (a) begin
            m_act = 1'b0;
            $display("job aborted at cycle %0d", m_cyc);
        end else begin
            m_cyc++;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]   e_in, e_acc;
        logic [N*N-1:0] e_w;
        int             t_len, t;
        bit             stream;
        t_len  = m_k + 2 * (N - 1);
        t      = m_cyc - 2;
        stream = m_act && (m_cyc >= 2) && (m_cyc <= t_len + 1);
        e_acc  = (m_act && m_cyc == 1) ? '1 : '0;
        for (int r = 0; r < N; r++) begin
            e_in[r] = stream && (t >= r) && (t <= r + m_k - 1);
            for (int c = 0; c < N; c++)
                e_w[r*N+c] = stream && (t >= r + c) && (t <= r + c + m_k - 1);
        end
        chk("input_rd_en",  32'(input_rd_en),  32'(e_in));
        chk("weight_rd_en", 32'(weight_rd_en), 32'(e_w));
        chk("acc_clear",    32'(acc_clear),    32'(e_acc));
        chk("busy",         32'(busy),         32'(m_act && m_cyc < m_len));
        chk("done",         32'(done),         32'(m_act && m_cyc == m_len));
        chk("obuf_valid",   32'(obuf_valid),   32'(m_act && m_cyc == m_len));
        chk("cfg_error",    32'(cfg_error),    32'(m_err));
        chk("cfg_input_bitwidth",  32'(cfg_input_bitwidth),  32'(m_ib));
        chk("cfg_weight_bitwidth", 32'(cfg_weight_bitwidth), 32'(m_wb));
    endtask

    task automatic step(input bit s, input bit a, input logic [2:0] i, input logic [2:0] w,
                        input logic [KW-1:0] k);
        @(negedge clk);
        start = s; abort = a; input_bitwidth = i; weight_bitwidth = w; k_len = k;
        @(posedge clk);
        model_edge(s, a, i, w, k);
        #1 check_outputs();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 3'd0, 3'd0, '0);
    endtask

    // Steps idle cycles until done is seen; returns the cycle count (0 on timeout).
    task automatic run_until_done(output int cycles);
        cycles = 0;
        for (int j = 1; j <= 100; j++) begin
            step(1'b0, 1'b0, 3'd0, 3'd0, '0);
            if (done === 1'b1) begin
                cycles = j;
                break;
            end
        end
        if (cycles == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    bit rs, ra;
    logic [2:0] ri, rw;
    logic [KW-1:0] rk;

    initial begin
        #1 check_outputs();
        #20 nRST = 1'b1;
        idle(2);

        // Basic wavefront: k_len=1 gives T=3, done at cycle 7.
        step(1'b1, 1'b0, 3'd1, 3'd1, 4'd1);
        run_until_done(lat);
        chk("latency_k1", 32'(lat + 1), 32'd7);
        idle(2);

        // Reset mid-job during stream cycle t=2 (cycle 4).
        step(1'b1, 1'b0, 3'd2, 3'd3, 4'd4);
        idle(3);
        #2 nRST = 1'b0;
        m_act = 1'b0; m_ib = '0; m_wb = '0; m_err = 1'b0;
        $display("async reset asserted mid-job");
        #1 check_outputs();
        @(negedge clk) nRST = 1'b1;
        idle(2);

        // Longest k_len exercises the counter boundary.
        step(1'b1, 1'b0, 3'd3, 3'd0, 4'd15);
        run_until_done(lat);
        chk("latency_k15", 32'(lat + 1), 32'd15 + 32'd2 + 32'd2 + 32'(DC));
        idle(1);

        // Illegal configurations leave cfg untouched.
        step(1'b1, 1'b0, 3'd5, 3'd1, 4'd3);
        step(1'b1, 1'b0, 3'd1, 3'd1, 4'd0);
        step(1'b1, 1'b0, 3'd0, 3'd7, 4'd2);
        idle(1);

        // Start together with abort in IDLE is dropped.
        step(1'b1, 1'b1, 3'd2, 3'd2, 4'd2);
        idle(1);

        // Abort in DRAIN (cycle 5 for k_len=1).
        step(1'b1, 1'b0, 3'd0, 3'd1, 4'd1);
        idle(4);
        step(1'b0, 1'b1, 3'd0, 3'd0, '0);
        idle(3);

        // Start during STREAM ignored, then back-to-back start in the DONE cycle.
        step(1'b1, 1'b0, 3'd1, 3'd2, 4'd3);
        idle(2);
        step(1'b1, 1'b0, 3'd3, 3'd3, 4'd5);
        run_until_done(lat);
        step(1'b1, 1'b0, 3'd2, 3'd0, 4'd2);
        chk("b2b_acc_clear", 32'(acc_clear), 32'(2'b11));
        run_until_done(lat);
        idle(2);

        // Random traffic.
        repeat (2500) begin
            rs = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 15) == 0);
            ri = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            rw = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)      rk = '0;
            else if ($urandom_range(0, 7) == 0) rk = 4'd15;
            else                                rk = KW'($urandom_range(1, 6));
            step(rs, ra, ri, rw, rk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
